lookup_cfg_writer: RTL and testbench

//  Control-plane initiator for one RMT stage's lookup tables. Accepts config packets on a 64b

---
 rtl/lookup_cfg_pkg.sv | 34 +++
 rtl/cfg_word_assembler.sv | 57 +++++
 rtl/lookup_cfg_writer.sv | 163 ++++++++++++++++
 tb/tb_lookup_cfg_writer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lookup_cfg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lookup_cfg_pkg : header layout, packet type codes, beat counts, FSM states
// Rev 1.0
// ---------------------------------------------------------------------------
package lookup_cfg_pkg;

   localparam int HDR_ADDR_LSB  = 0;
   localparam int HDR_STAGE_LSB = 4;
   localparam int HDR_STAGE_W   = 4;
   localparam int HDR_TYPE_LSB  = 8;
   localparam int HDR_TYPE_W    = 2;

   localparam logic [1:0] TYPE_CAM = 2'd0;
   localparam logic [1:0] TYPE_ACT = 2'd1;

   localparam int CAM_BEATS = 16;

   // Number of stream beats needed to cover a word of the given width.
   function automatic int beats_for(input int width, input int beat_w);
      return (width + beat_w - 1) / beat_w;
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_KEY    = 3'd1,
      ST_MASK   = 3'd2,
      ST_ACT    = 3'd3,
      ST_COMMIT = 3'd4,
      ST_DRAIN  = 3'd5
   } cfg_state_t;

endpackage
`default_nettype wire

// File: rtl/cfg_word_assembler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cfg_word_assembler : shifts stream beats into a W-bit word, beat 0 in LSBs
// Rev 1.0
// ---------------------------------------------------------------------------
module cfg_word_assembler
   import lookup_cfg_pkg::*;
#(
   parameter int W      = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data,
   input  logic              load,
   input  logic              clear,
   output logic [W-1:0]      word,
   output logic              done
);

   localparam int BEATS = beats_for(W, DATA_W);
   localparam int TOT_W = BEATS * DATA_W;
   localparam int CNT_W = $clog2(BEATS + 1);

   logic [TOT_W-1:0] r_shift;
   logic [TOT_W-1:0] w_shifted;
   logic [TOT_W-1:0] w_shift_nxt;
   logic [CNT_W-1:0] r_cnt;

   generate
      if (BEATS > 1) begin : g_multi
         assign w_shifted = {data, r_shift[TOT_W-1:DATA_W]};
      end else begin : g_single
         assign w_shifted = data;
      end
   endgenerate

   assign w_shift_nxt = load ? w_shifted : r_shift;
   // word includes the beat loaded this cycle so the final beat is usable at once
   assign word        = w_shift_nxt[W-1:0];
   assign done        = load && (r_cnt == CNT_W'(BEATS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else begin
         r_shift <= w_shift_nxt;
         if (clear)
            r_cnt <= '0;
         else if (load)
            r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/lookup_cfg_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lookup_cfg_writer : config-stream to lookup-engine CAM / action RAM writer
// Rev 1.0
// ---------------------------------------------------------------------------
module lookup_cfg_writer
   import lookup_cfg_pkg::*;
#(
   parameter int STAGE  = 0,
   parameter int DATA_W = 64,
   parameter int CAM_W  = 1024,
   parameter int ACT_W  = 625,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic              s_tvalid,
   input  logic              s_tlast,
   output logic              s_tready,
   output logic [CAM_W-1:0]  lookup_din,
   output logic [CAM_W-1:0]  lookup_din_mask,
   output logic [ADDR_W-1:0] lookup_din_addr,
   output logic              lookup_din_en,
   output logic [ACT_W-1:0]  action_data_in,
   output logic [ADDR_W-1:0] action_addr,
   output logic              action_en,
   output logic [15:0]       cfg_err_cnt
);

   cfg_state_t        r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic              w_hs, w_stage_ok, w_type_ok;
   logic [1:0]        w_type;
   logic              w_clear, w_addr_ld, w_err_inc;
   logic              w_key_load, w_mask_load, w_act_load;
   logic              w_key_done, w_mask_done, w_act_done;
   logic              w_cam_commit, w_act_commit;
   logic [CAM_W-1:0]  w_key_word, w_mask_word;
   logic [ACT_W-1:0]  w_act_word;

   assign s_tready   = (r_state != ST_COMMIT);
   assign w_hs       = s_tvalid && s_tready;
   assign w_type     = s_tdata[HDR_TYPE_LSB +: HDR_TYPE_W];
   assign w_stage_ok = (s_tdata[HDR_STAGE_LSB +: HDR_STAGE_W] == HDR_STAGE_W'(STAGE));
   assign w_type_ok  = (w_type == TYPE_CAM) || (w_type == TYPE_ACT);

   cfg_word_assembler #(.W(CAM_W), .DATA_W(DATA_W)) u_key (
      .clk(clk), .rst(rst), .data(s_tdata), .load(w_key_load), .clear(w_clear),
      .word(w_key_word), .done(w_key_done));

   cfg_word_assembler #(.W(CAM_W), .DATA_W(DATA_W)) u_mask (
      .clk(clk), .rst(rst), .data(s_tdata), .load(w_mask_load), .clear(w_clear),
      .word(w_mask_word), .done(w_mask_done));

   cfg_word_assembler #(.W(ACT_W), .DATA_W(DATA_W)) u_act (
      .clk(clk), .rst(rst), .data(s_tdata), .load(w_act_load), .clear(w_clear),
      .word(w_act_word), .done(w_act_done));

   always_comb begin
      w_state_nxt  = r_state;
      w_clear      = 1'b0;
      w_addr_ld    = 1'b0;
      w_err_inc    = 1'b0;
      w_key_load   = 1'b0;
      w_mask_load  = 1'b0;
      w_act_load   = 1'b0;
      w_cam_commit = 1'b0;
      w_act_commit = 1'b0;
      case (r_state)
         ST_IDLE: if (w_hs) begin
            w_clear   = 1'b1;
            w_addr_ld = 1'b1;
            // packets for other stages are swallowed silently
            if (!w_stage_ok) begin
               w_state_nxt = s_tlast ? ST_IDLE : ST_DRAIN;
            end else if (!w_type_ok) begin
               w_err_inc   = 1'b1;
               w_state_nxt = s_tlast ? ST_IDLE : ST_DRAIN;
            end else if (s_tlast) begin
               w_err_inc = 1'b1;
            end else begin
               w_state_nxt = (w_type == TYPE_CAM) ? ST_KEY : ST_ACT;
            end
         end
         ST_KEY: if (w_hs) begin
            w_key_load = 1'b1;
            if (s_tlast) begin
               w_err_inc   = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (w_key_done) begin
               w_state_nxt = ST_MASK;
            end
         end
         ST_MASK: if (w_hs) begin
            w_mask_load = 1'b1;
            if (w_mask_done) begin
               w_cam_commit = s_tlast;
               w_err_inc    = !s_tlast;
               w_state_nxt  = s_tlast ? ST_COMMIT : ST_DRAIN;
            end else if (s_tlast) begin
               w_err_inc   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ACT: if (w_hs) begin
            w_act_load = 1'b1;
            if (w_act_done) begin
               w_act_commit = s_tlast;
               w_err_inc    = !s_tlast;
               w_state_nxt  = s_tlast ? ST_COMMIT : ST_DRAIN;
            end else if (s_tlast) begin
               w_err_inc   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_COMMIT: w_state_nxt = ST_IDLE;
         ST_DRAIN:  if (w_hs && s_tlast) w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         cfg_err_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_addr_ld)
            r_addr <= s_tdata[HDR_ADDR_LSB +: ADDR_W];
         if (w_err_inc && (cfg_err_cnt != 16'hFFFF))
            cfg_err_cnt <= cfg_err_cnt + 16'd1;
      end
   end

   // Outputs load on the final-beat handshake so data, addr and strobe align in COMMIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lookup_din      <= '0;
         lookup_din_mask <= '0;
         lookup_din_addr <= '0;
         lookup_din_en   <= 1'b0;
         action_data_in  <= '0;
         action_addr     <= '0;
         action_en       <= 1'b0;
      end else begin
         lookup_din_en <= w_cam_commit;
         action_en     <= w_act_commit;
         if (w_cam_commit) begin
            lookup_din      <= w_key_word;
            lookup_din_mask <= w_mask_word;
            lookup_din_addr <= r_addr;
         end
         if (w_act_commit) begin
            action_data_in <= w_act_word;
            action_addr    <= r_addr;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lookup_cfg_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lookup_cfg_writer : randomized bench with a packet-level reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_lookup_cfg_writer;

   localparam int DATA_W = 64;
   localparam int CAM_W  = 1024;
   localparam int ACT_W  = 625;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] s_tdata;
   logic              s_tvalid;
   logic              s_tlast;
   logic              s_tready;
   logic [CAM_W-1:0]  lookup_din, lookup_din_mask;
   logic [ADDR_W-1:0] lookup_din_addr, action_addr;
   logic              lookup_din_en, action_en;
   logic [ACT_W-1:0]  action_data_in;
   logic [15:0]       cfg_err_cnt;

   lookup_cfg_writer #(.STAGE(0), .DATA_W(DATA_W), .CAM_W(CAM_W), .ACT_W(ACT_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
      .s_tready(s_tready), .lookup_din(lookup_din), .lookup_din_mask(lookup_din_mask),
      .lookup_din_addr(lookup_din_addr), .lookup_din_en(lookup_din_en),
      .action_data_in(action_data_in), .action_addr(action_addr), .action_en(action_en),
      .cfg_err_cnt(cfg_err_cnt));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cam_cnt = 0, act_cnt = 0, overlap = 0;

   always @(negedge clk) begin
      if (lookup_din_en) cam_cnt++;
      if (action_en) act_cnt++;
      if (lookup_din_en && action_en) overlap++;
   end

   // reference model: what the engine should hold after each whole packet
   logic [CAM_W-1:0]  m_din, m_mask;
   logic [ADDR_W-1:0] m_din_addr, m_act_addr;
   logic [ACT_W-1:0]  m_act;
   int                m_err;
   logic [63:0]       pay [0:63];

   task automatic model_reset();
      m_din = '0; m_mask = '0; m_din_addr = '0; m_act = '0; m_act_addr = '0; m_err = 0;
   endtask

   // kind: 0 = no write, 1 = CAM write, 2 = action write
   task automatic model_apply(input logic [63:0] hdr, input int n, output int kind);
      logic [1023:0] kw, mw;
      logic [639:0]  aw;
      int            need;
      kind = 0;
      if (hdr[7:4] != 4'd0) return;
      if (hdr[9:8] > 2'd1) begin
         if (m_err < 65535) m_err++;
         return;
      end
      need = (hdr[9:8] == 2'd0) ? 32 : 10;
      if (n != need) begin
         if (m_err < 65535) m_err++;
         return;
      end
      if (hdr[9:8] == 2'd0) begin
         for (int i = 0; i < 16; i++) begin
            kw[i*64 +: 64] = pay[i];
            mw[i*64 +: 64] = pay[16+i];
         end
         m_din = kw; m_mask = mw; m_din_addr = hdr[3:0]; kind = 1;
      end else begin
         for (int i = 0; i < 10; i++) aw[i*64 +: 64] = pay[i];
         m_act = aw[ACT_W-1:0]; m_act_addr = hdr[3:0]; kind = 2;
      end
   endtask

   function automatic logic [63:0] mk_hdr(input int stage, input int typ, input int addr);
      logic [63:0] h;
      h = {$urandom, $urandom};
      h[3:0] = addr[3:0];
      h[7:4] = stage[3:0];
      h[9:8] = typ[1:0];
      return h;
   endfunction

   // Entered and left on a falling edge; the handshake lands on the rising edge in between.
   task automatic drive_beat(input logic [63:0] d, input bit last, input bit gaps, output int waited);
      waited = 0;
      if (gaps && $urandom_range(0, 3) == 0) begin
         s_tvalid = 1'b0;
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      s_tdata = d; s_tvalid = 1'b1; s_tlast = last;
      while (!s_tready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      total++;
      if (waited >= 50) begin
         bad++;
         $display("FAIL handshake_timeout: s_tready=%b after %0d cycles, want 1", s_tready, waited);
      end
      @(negedge clk);
   endtask

   task automatic send_pkt(input logic [63:0] hdr, input int n, input bit gaps, output int hdr_wait);
      int w;
      drive_beat(hdr, (n == 0), gaps, hdr_wait);
      for (int i = 0; i < n; i++) drive_beat(pay[i], (i == n - 1), gaps, w);
   endtask

   task automatic test_reset();
      rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
      repeat (3) @(negedge clk);
      total += 4;
      if (s_tready !== 1'b1) begin bad++; $display("FAIL reset_tready: got %b want 1", s_tready); end
      if ({lookup_din_en, action_en} !== 2'b00) begin bad++; $display("FAIL reset_strobes: got %b want 00", {lookup_din_en, action_en}); end
      if (cfg_err_cnt !== 16'd0) begin bad++; $display("FAIL reset_err: got %0d want 0", cfg_err_cnt); end
      if (lookup_din !== '0 || lookup_din_mask !== '0 || action_data_in !== '0 || lookup_din_addr !== '0 || action_addr !== '0) begin
         bad++; $display("FAIL reset_data: din_lo=%h act_lo=%h want 0", lookup_din[63:0], action_data_in[63:0]);
      end
      rst = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   task automatic test_cam();
      logic [63:0] hdr;
      int kind, w;
      for (int i = 0; i < 16; i++) begin
         pay[i] = {$urandom, $urandom};
         pay[16+i] = ~pay[i];
      end
      hdr = mk_hdr(0, 0, 5);
      model_apply(hdr, 32, kind);
      send_pkt(hdr, 32, 1'b0, w);
      s_tvalid = 1'b0;
      total += 5;
      if (lookup_din_en !== 1'b1) begin bad++; $display("FAIL cam_strobe: got %b want 1", lookup_din_en); end
      if (action_en !== 1'b0) begin bad++; $display("FAIL cam_act_quiet: got %b want 0", action_en); end
      if (lookup_din_addr !== 4'd5) begin bad++; $display("FAIL cam_addr: got %0d want 5", lookup_din_addr); end
      if (lookup_din !== m_din) begin bad++; $display("FAIL cam_din: got_lo=%h want_lo=%h", lookup_din[63:0], m_din[63:0]); end
      if (lookup_din_mask !== ~m_din) begin bad++; $display("FAIL cam_mask: got_lo=%h want_lo=%h", lookup_din_mask[63:0], ~m_din[63:0]); end
      @(negedge clk);
      total += 2;
      if (lookup_din_en !== 1'b0) begin bad++; $display("FAIL cam_pulse_width: got %b want 0", lookup_din_en); end
      if (cfg_err_cnt !== 16'(m_err)) begin bad++; $display("FAIL cam_err: got %0d want %0d", cfg_err_cnt, m_err); end
   endtask

   task automatic test_act();
      logic [63:0] hdr;
      int kind, w;
      for (int i = 0; i < 10; i++) pay[i] = 64'hA5A5_A5A5_A5A5_A5A5;
      hdr = mk_hdr(0, 1, 3);
      model_apply(hdr, 10, kind);
      send_pkt(hdr, 10, 1'b1, w);
      s_tvalid = 1'b0;
      total += 4;
      if (action_en !== 1'b1) begin bad++; $display("FAIL act_strobe: got %b want 1", action_en); end
      if (lookup_din_en !== 1'b0) begin bad++; $display("FAIL act_cam_quiet: got %b want 0", lookup_din_en); end
      if (action_addr !== 4'd3) begin bad++; $display("FAIL act_addr: got %0d want 3", action_addr); end
      if (action_data_in !== m_act) begin bad++; $display("FAIL act_data: got_hi=%h want_hi=%h", action_data_in[ACT_W-1:ACT_W-49], m_act[ACT_W-1:ACT_W-49]); end
      @(negedge clk);
   endtask

   task automatic test_foreign_stage();
      logic [63:0] hdr;
      int kind, w, c0, a0;
      c0 = cam_cnt; a0 = act_cnt;
      for (int i = 0; i < 32; i++) pay[i] = {$urandom, $urandom};
      hdr = mk_hdr(2, 0, 9);
      model_apply(hdr, 32, kind);
      send_pkt(hdr, 32, 1'b1, w);
      s_tvalid = 1'b0;
      repeat (3) @(negedge clk);
      total += 3;
      if (cam_cnt != c0 || act_cnt != a0) begin bad++; $display("FAIL foreign_strobes: got %0d/%0d want 0/0", cam_cnt - c0, act_cnt - a0); end
      if (cfg_err_cnt !== 16'(m_err)) begin bad++; $display("FAIL foreign_err: got %0d want %0d", cfg_err_cnt, m_err); end
      if (lookup_din_addr !== m_din_addr || lookup_din !== m_din) begin bad++; $display("FAIL foreign_hold: addr got %0d want %0d", lookup_din_addr, m_din_addr); end
   endtask

   task automatic test_early_tlast();
      logic [63:0] hdr;
      int kind, w, c0;
      c0 = cam_cnt;
      for (int i = 0; i < 32; i++) pay[i] = {$urandom, $urandom};
      hdr = mk_hdr(0, 0, 7);
      model_apply(hdr, 20, kind);
      send_pkt(hdr, 20, 1'b0, w);
      s_tvalid = 1'b0;
      repeat (3) @(negedge clk);
      total += 3;
      if (cam_cnt != c0) begin bad++; $display("FAIL early_strobe: got %0d want 0", cam_cnt - c0); end
      if (cfg_err_cnt !== 16'(m_err) || m_err != 1) begin bad++; $display("FAIL early_err: got %0d want 1", cfg_err_cnt); end
      if (lookup_din !== m_din || lookup_din_addr !== 4'd5) begin bad++; $display("FAIL early_hold: addr got %0d want 5", lookup_din_addr); end
      for (int i = 0; i < 10; i++) pay[i] = {$urandom, $urandom};
      hdr = mk_hdr(0, 1, 12);
      model_apply(hdr, 10, kind);
      send_pkt(hdr, 10, 1'b0, w);
      s_tvalid = 1'b0;
      total += 2;
      if (action_en !== 1'b1) begin bad++; $display("FAIL after_early_strobe: got %b want 1", action_en); end
      if (action_data_in !== m_act || action_addr !== 4'd12) begin bad++; $display("FAIL after_early_data: addr got %0d want 12", action_addr); end
      @(negedge clk);
   endtask

   task automatic test_overrun();
      logic [63:0] hdr;
      int kind, w, a0;
      a0 = act_cnt;
      for (int i = 0; i < 13; i++) pay[i] = {$urandom, $urandom};
      hdr = mk_hdr(0, 1, 1);
      model_apply(hdr, 13, kind);
      send_pkt(hdr, 13, 1'b1, w);
      s_tvalid = 1'b0;
      repeat (3) @(negedge clk);
      total += 3;
      if (act_cnt != a0) begin bad++; $display("FAIL overrun_strobe: got %0d want 0", act_cnt - a0); end
      if (cfg_err_cnt !== 16'(m_err)) begin bad++; $display("FAIL overrun_err: got %0d want %0d", cfg_err_cnt, m_err); end
      if (action_data_in !== m_act || action_addr !== m_act_addr) begin bad++; $display("FAIL overrun_hold: addr got %0d want %0d", action_addr, m_act_addr); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] hdr;
      int kind, w;
      for (int i = 0; i < 32; i++) pay[i] = {$urandom, $urandom};
      hdr = mk_hdr(0, 0, 14);
      model_apply(hdr, 32, kind);
      send_pkt(hdr, 32, 1'b0, w);
      total += 1;
      if (lookup_din_en !== 1'b1 || lookup_din !== m_din || lookup_din_mask !== m_mask) begin
         bad++; $display("FAIL b2b_cam: en=%b din_lo=%h want_lo=%h", lookup_din_en, lookup_din[63:0], m_din[63:0]);
      end
      for (int i = 0; i < 10; i++) pay[i] = {$urandom, $urandom};
      hdr = mk_hdr(0, 1, 6);
      model_apply(hdr, 10, kind);
      send_pkt(hdr, 10, 1'b0, w);
      s_tvalid = 1'b0;
      total += 2;
      if (w != 1) begin bad++; $display("FAIL b2b_bubble: got %0d want 1", w); end
      if (action_en !== 1'b1 || action_data_in !== m_act || action_addr !== 4'd6) begin
         bad++; $display("FAIL b2b_act: en=%b addr=%0d want addr 6", action_en, action_addr);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [63:0] hdr;
      int kind, w, c0, a0, st, ty, n;
      for (int p = 0; p < 40; p++) begin
         st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
         ty = $urandom_range(0, 3);
         if ($urandom_range(0, 1) == 1) n = (ty == 1) ? 10 : 32;
         else n = $urandom_range(0, 40);
         if (st != 0 && n == 0) n = 1;
         for (int i = 0; i < n; i++) pay[i] = {$urandom, $urandom};
         hdr = mk_hdr(st, ty, $urandom_range(0, 15));
         c0 = cam_cnt; a0 = act_cnt;
         model_apply(hdr, n, kind);
         send_pkt(hdr, n, 1'b1, w);
         s_tvalid = 1'b0;
         repeat (3) @(negedge clk);
         total += 5;
         if (cam_cnt - c0 != ((kind == 1) ? 1 : 0)) begin bad++; $display("FAIL rand_cam_cnt p%0d: got %0d want %0d", p, cam_cnt - c0, (kind == 1)); end
         if (act_cnt - a0 != ((kind == 2) ? 1 : 0)) begin bad++; $display("FAIL rand_act_cnt p%0d: got %0d want %0d", p, act_cnt - a0, (kind == 2)); end
         if (cfg_err_cnt !== 16'(m_err)) begin bad++; $display("FAIL rand_err p%0d: got %0d want %0d", p, cfg_err_cnt, m_err); end
         if (lookup_din !== m_din || lookup_din_mask !== m_mask || lookup_din_addr !== m_din_addr) begin
            bad++; $display("FAIL rand_cam_data p%0d: addr got %0d want %0d din_lo %h want %h", p, lookup_din_addr, m_din_addr, lookup_din[63:0], m_din[63:0]);
         end
         if (action_data_in !== m_act || action_addr !== m_act_addr) begin
            bad++; $display("FAIL rand_act_data p%0d: addr got %0d want %0d", p, action_addr, m_act_addr);
         end
      end
      total += 1;
      if (overlap != 0) begin bad++; $display("FAIL strobe_overlap: got %0d want 0", overlap); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] hdr;
      int kind, w, c0;
      c0 = cam_cnt;
      for (int i = 0; i < 32; i++) pay[i] = {$urandom, $urandom};
      hdr = mk_hdr(0, 0, 2);
      drive_beat(hdr, 1'b0, 1'b1, w);
      for (int i = 0; i < 10; i++) drive_beat(pay[i], 1'b0, 1'b1, w);
      #2 rst = 1'b1;
      #1;
      total += 3;
      if (lookup_din !== '0 || lookup_din_mask !== '0 || action_data_in !== '0 || lookup_din_addr !== '0 || action_addr !== '0) begin
         bad++; $display("FAIL midrst_outputs: din_lo=%h act_lo=%h want 0", lookup_din[63:0], action_data_in[63:0]);
      end
      if (s_tready !== 1'b1 || cfg_err_cnt !== 16'd0) begin bad++; $display("FAIL midrst_state: tready=%b err=%0d want 1/0", s_tready, cfg_err_cnt); end
      s_tvalid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      if (cam_cnt != c0) begin bad++; $display("FAIL midrst_strobe: got %0d want 0", cam_cnt - c0); end
      for (int i = 0; i < 32; i++) pay[i] = {$urandom, $urandom};
      hdr = mk_hdr(0, 0, 11);
      model_apply(hdr, 32, kind);
      send_pkt(hdr, 32, 1'b1, w);
      s_tvalid = 1'b0;
      total += 2;
      if (lookup_din_en !== 1'b1 || lookup_din_addr !== 4'd11) begin bad++; $display("FAIL postrst_strobe: en=%b addr=%0d want 1/11", lookup_din_en, lookup_din_addr); end
      if (lookup_din !== m_din || lookup_din_mask !== m_mask || cfg_err_cnt !== 16'd0) begin
         bad++; $display("FAIL postrst_data: din_lo=%h want_lo=%h err=%0d", lookup_din[63:0], m_din[63:0], cfg_err_cnt);
      end
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_cam();
      test_act();
      test_foreign_stage();
      test_early_tlast();
      test_overrun();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
